result_buffer: RTL and testbench
================================

RESULT_BUFFER -- requirements
Module: result_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, number of result entries (power of two, 2..16).
REQ-002 The block SHALL have parameter WIDTH, default 32, sum width matching the upstream adder stage.
REQ-003 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port in_valid, input, 1, upstream registered sum is valid this cycle.
REQ-006 Port in_sum, input, WIDTH, registered sum from the adder stage.
REQ-007 Port in_cout, input, 1, carry-out from the adder stage.
REQ-008 Port in_ready, output, 1, high when the buffer is not full.
REQ-009 Port out_valid, output, 1, head entry is available.
REQ-010 Port out_ready, input, 1, downstream accepts the head entry.
REQ-011 Port out_sum, output, WIDTH, head entry sum.
REQ-012 Port out_cout, output, 1, head entry carry.
REQ-013 Port out_zero and out_neg, output, 1 each, head entry flags (see Configuration).
REQ-014 Port count, output, $clog2(DEPTH)+1, current number of stored entries.
REQ-015 Port drop_err, output, 1, sticky flag: a write was attempted while full.

Function
- REQ-016 Write SHALL occur when in_valid && in_ready; read SHALL occur when out_valid && out_ready.
- REQ-017 Storage SHALL be a circular buffer with write and read pointers wrapping from DEPTH-1 to 0.
- REQ-018 out_sum, out_cout and flags SHALL be driven from the head entry with zero added latency, valid whenever count != 0.
- REQ-019 An entry written in cycle N SHALL appear at the head no earlier than cycle N+1 (no write-through when empty).
- REQ-020 in_ready SHALL equal (count != DEPTH); out_valid SHALL equal (count != 0).
- REQ-021 Simultaneous write and read SHALL leave count unchanged; when full, a simultaneous read does NOT enable the write (in_ready stays low).
- REQ-022 in_valid while full SHALL discard the data, leave state unchanged and set drop_err until reset.
- REQ-023 out_ready while empty SHALL have no effect.
- REQ-024 count SHALL never exceed DEPTH nor underflow.

Reset
- REQ-025 On rst high at a clock edge: pointers, count = 0, drop_err = 0, out_valid = 0, in_ready = 1.
- REQ-026 Reset SHALL take precedence over a write or read in the same cycle; stored entries are discarded.
- REQ-027 While empty, out_sum SHALL read 0 and out_cout, out_zero, out_neg SHALL read 0.

Configuration
- REQ-028 With RESULT_FLAGS_EN defined: out_zero = (stored sum == 0), out_neg = stored sum[WIDTH-1], computed at write time and stored per entry.
- REQ-029 Without RESULT_FLAGS_EN: out_zero and out_neg SHALL be tied 0 and no flag storage is built.

Structure
- REQ-030 A shared package alu_pkg SHALL hold WIDTH default, the result-entry typedef (sum, cout, zero, neg) and DEPTH default.
- REQ-031 Pointer/count logic SHALL be one sub-module, buf_ctrl; storage array stays in result_buffer.

Verification
- REQ-032 Reset, then write 0x0000_0005/cout 0 -> next cycle out_valid=1, out_sum=0x5, count=1, in_ready=1.
- REQ-033 Write four sums 1,2,3,4 with out_ready=0 -> count=4, in_ready=0; drain -> outputs 1,2,3,4 in order, count=0.
- REQ-034 Full buffer, in_valid=1 with 0xDEAD_BEEF -> dropped, drop_err=1 and stays 1 after draining, cleared only by rst.
- REQ-035 count=2, simultaneous write and read for 10 cycles -> count stays 2, pointers wrap, order preserved.
- REQ-036 RESULT_FLAGS_EN defined: write 0x0000_0000 -> out_zero=1; write 0x8000_0001 with cout 1 -> out_neg=1, out_cout=1; undefined -> both flags 0.
- REQ-037 rst asserted with count=3 and simultaneous write -> next cycle count=0, out_valid=0, drop_err=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared defaults and result-entry layout for the adder result path.
package alu_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] sum;
    logic                 cout;
    logic                 zero;
    logic                 neg;
  } result_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/buf_ctrl.sv
// Pointer, occupancy and overflow tracking for the result buffer.
module buf_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     out_ready,
  output logic                     wr_en,
  output logic                     rd_en,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic                     drop_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Full blocks writes even when a read happens in the same cycle.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign wr_en     = in_valid && in_ready;
  assign rd_en     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= nxt(wr_ptr);
      if (rd_en) rd_ptr <= nxt(rd_ptr);
      if (wr_en && !rd_en)      count <= count + 1'b1;
      else if (!wr_en && rd_en) count <= count - 1'b1;
      if (in_valid && !in_ready) drop_err <= 1'b1;
    end
  end
endmodule

// File: rtl/result_buffer.sv
// Circular result buffer behind the adder stage; head entry shown with no added latency.
// Optional per-entry zero/negative flags built when RESULT_FLAGS_EN is defined.
module result_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_sum,
  input  logic                     in_cout,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic                     out_cout,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop_err
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef RESULT_FLAGS_EN
    logic             zero;
    logic             neg;
`endif
  } entry_t;

  logic          wr_en, rd_en;
  logic [PW-1:0] wr_ptr, rd_ptr;
  entry_t        mem [DEPTH];
  entry_t        wr_entry, head;

  buf_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .drop_err  (drop_err)
  );

  always_comb begin
    wr_entry      = '0;
    wr_entry.sum  = in_sum;
    wr_entry.cout = in_cout;
`ifdef RESULT_FLAGS_EN
    wr_entry.zero = (in_sum == '0);
    wr_entry.neg  = in_sum[WIDTH-1];
`endif
  end

  // Storage needs no reset: an empty buffer masks the head to zero.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  assign head     = mem[rd_ptr];
  assign out_sum  = out_valid ? head.sum : '0;
  assign out_cout = out_valid & head.cout;
`ifdef RESULT_FLAGS_EN
  assign out_zero = out_valid & head.zero;
  assign out_neg  = out_valid & head.neg;
`else
  assign out_zero = 1'b0;
  assign out_neg  = 1'b0;
`endif
endmodule

// File: tb/tb_result_buffer.sv
// Randomized plus directed bench for result_buffer against a queue reference model.
module tb_result_buffer;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
`ifdef RESULT_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, in_valid, in_cout, out_ready;
  logic [WIDTH-1:0] in_sum;
  logic             in_ready, out_valid, out_cout, out_zero, out_neg, drop_err;
  logic [WIDTH-1:0] out_sum;
  logic [$clog2(DEPTH):0] count;

  result_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sum(in_sum), .in_cout(in_cout),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_zero(out_zero), .out_neg(out_neg),
    .count(count), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [WIDTH-1:0] sum; logic cout; } ent_t;
  ent_t q[$];
  bit   m_drop;
  int   total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs();
    logic [WIDTH-1:0] es;
    logic ec;
    es = '0; ec = 1'b0;
    if (q.size() != 0) begin es = q[0].sum; ec = q[0].cout; end
    chk("in_ready", in_ready, q.size() != DEPTH);
    chk("out_valid", out_valid, q.size() != 0);
    chk("count", count, q.size());
    chk("drop_err", drop_err, m_drop);
    chk("out_sum", out_sum, es);
    chk("out_cout", out_cout, ec);
    chk("out_zero", out_zero, FLAGS && q.size() != 0 && es == '0);
    chk("out_neg", out_neg, FLAGS && q.size() != 0 && es[WIDTH-1]);
  endtask

  // Drive one cycle at the falling edge, check pre-edge outputs, advance the model.
  task automatic step(input bit r, input bit v, input logic [WIDTH-1:0] s,
                      input bit c, input bit rdy);
    bit   full, emp;
    ent_t e;
    rst = r; in_valid = v; in_sum = s; in_cout = c; out_ready = rdy;
    #1 check_outs();
    full = (q.size() == DEPTH);
    emp  = (q.size() == 0);
    @(posedge clk);
    if (r) begin
      q.delete();
      m_drop = 1'b0;
    end else begin
      if (rdy && !emp) void'(q.pop_front());
      if (v && !full) begin e.sum = s; e.cout = c; q.push_back(e); end
      if (v && full) m_drop = 1'b1;
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    int bias;
    logic [WIDTH-1:0] rs;
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_cout = 1'b0; out_ready = 1'b0;
    m_drop = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_outs();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_count", count, 0);

    // single write, visible next cycle only
    step(0, 1, 32'h5, 0, 0);
    chk("w1_valid", out_valid, 1'b1);
    chk("w1_sum", out_sum, 32'h5);
    chk("w1_count", count, 1);
    step(0, 0, 0, 0, 1);

    // fill 1..4 then drain in order
    for (int i = 1; i <= 4; i++) step(0, 1, i, 0, 0);
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 1'b0);
    // overflow attempt, then read+write while full: write must still be refused
    step(0, 1, 32'hDEAD_BEEF, 1, 0);
    chk("drop_set", drop_err, 1'b1);
    step(0, 1, 32'hDEAD_BEEF, 1, 1);
    chk("full_rd_count", count, 3);
    for (int i = 2; i <= 4; i++) begin
      chk("drain_order", out_sum, i);
      step(0, 0, 0, 0, 1);
    end
    chk("drained", count, 0);
    chk("drop_sticky", drop_err, 1'b1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    chk("drop_clr", drop_err, 1'b0);

    // steady-state read+write at count=2, pointers wrap
    step(0, 1, 32'h10, 0, 0);
    step(0, 1, 32'h11, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 32'h20 + i, i[0], 1);
      chk("rw_count", count, 2);
    end

    // flag entries
    step(1, 0, 0, 0, 0);
    step(0, 1, 32'h0, 0, 0);
    chk("flag_zero", out_zero, FLAGS);
    step(0, 1, 32'h8000_0001, 1, 1);
    chk("flag_neg", out_neg, FLAGS);
    chk("flag_cout", out_cout, 1'b1);

    // reset wins over a simultaneous write at count=3
    step(0, 1, 32'h7, 0, 0);
    step(0, 1, 32'h8, 0, 0);
    chk("pre_rst_count", count, 3);
    step(1, 1, 32'h9, 0, 1);
    chk("rst_w_count", count, 0);
    chk("rst_w_valid", out_valid, 1'b0);

    // random traffic with alternating fill/drain bias
    bias = 20;
    for (int n = 0; n < 600; n++) begin
      if (n % 50 == 0) bias = (bias == 20) ? 80 : 20;
      case ($urandom_range(0, 3))
        0:       rs = '0;
        1:       rs = 32'h8000_0000 | $urandom;
        default: rs = $urandom;
      endcase
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, rs,
           $urandom_range(0, 1) == 1, $urandom_range(0, 99) < bias);
    end
    check_outs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
